pipe_skid_reg: RTL and testbench

Parametrised pipeline-stage register, the successor to the fixed 32-bit PC/instruction latch between fetch and decode. It carries an arbitrary-width payload (default PC+instruction, 64 bits) with a valid/ready handshake, a 2-entry skid buffer for full throughput under back-pressure, and a synchronous flush that injects a bubble. It is instantiated at every stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB) of the pipeline.

---
 rtl/pipe_skid_reg_pkg.sv | 25 ++
 rtl/pipe_skid_reg_if.sv | 49 ++++
 rtl/pipe_skid_reg.sv | 113 +++++++++++
 tb/tb_pipe_skid_reg.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_skid_reg_pkg.sv
// ---------------------------------------------------------------------------
// pipe_skid_reg_pkg
// Shared definitions for the pipeline-stage skid register:
//   - state encoding (the state value doubles as the occupancy count)
//   - default payload width for each stage boundary
//   - bubble constants (MIPS nop / zero word)
// ---------------------------------------------------------------------------
package pipe_skid_reg_pkg;

    // State value equals the number of held entries, so occ is the state register.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } skid_state_t;

    // Payload widths per stage boundary.
    localparam int IFID_W = 64;    // {pc[31:0], inst[31:0]}

    // Bubble constants: an all-zero instruction word is a MIPS nop (sll $0,$0,0).
    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
    localparam logic [31:0] NOP_INST  = 32'h0000_0000;
    localparam logic [IFID_W-1:0] IFID_BUBBLE = {ZERO_WORD, NOP_INST};

endpackage

// File: rtl/pipe_skid_reg_if.sv
// ---------------------------------------------------------------------------
// pipe_skid_reg_if
// Handshake bundle for one pipeline-stage boundary.
//   flush      : discard everything held plus this cycle's offer
//   in_valid   : upstream offers in_data
//   in_ready   : stage can accept (transfer on in_valid & in_ready)
//   in_data    : upstream payload
//   out_valid  : out_data holds a valid entry
//   out_ready  : downstream accepts (transfer on out_valid & out_ready)
//   out_data   : downstream payload (BUBBLE when out_valid is low)
//   occ        : number of held entries, 0..2
// Modports:
//   master : the environment around the stage (upstream + downstream side)
//   slave  : the stage register itself
// ---------------------------------------------------------------------------
interface pipe_skid_reg_if #(
    parameter int DATA_W = pipe_skid_reg_pkg::IFID_W
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occ;

    modport master (
        output flush,
        output in_valid,
        input  in_ready,
        output in_data,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  occ
    );

    modport slave (
        input  flush,
        input  in_valid,
        output in_ready,
        input  in_data,
        output out_valid,
        input  out_ready,
        output out_data,
        output occ
    );
endinterface

// File: rtl/pipe_skid_reg.sv
// ---------------------------------------------------------------------------
// pipe_skid_reg
// Pipeline-stage register with valid/ready handshake and a 2-entry skid
// buffer, so a stage boundary sustains one transfer per cycle even though
// in_ready is registered. A synchronous flush empties the stage and puts
// BUBBLE on out_data.
// Ports:
//   clk  : clock, all state updates on posedge
//   rst  : synchronous, active-high reset
//   bus  : pipe_skid_reg_if.slave (flush, in_* / out_* handshake, occ)
// Parameters:
//   DATA_W : payload width
//   BUBBLE : value driven on out_data whenever no valid entry is held
// Every output is taken directly from a flop; nothing on an input reaches
// an output within the same cycle.
// ---------------------------------------------------------------------------
module pipe_skid_reg
    import pipe_skid_reg_pkg::*;
#(
    parameter int                DATA_W = IFID_W,
    parameter logic [DATA_W-1:0] BUBBLE = '0
) (
    input  logic           clk,
    input  logic           rst,
    pipe_skid_reg_if.slave bus
);

    skid_state_t       r_state;
    logic              r_in_ready;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_main;
    logic [DATA_W-1:0] r_skid;

    skid_state_t       w_state_nxt;
    logic [DATA_W-1:0] w_main_nxt;
    logic [DATA_W-1:0] w_skid_nxt;
    logic              w_acc;
    logic              w_pop;

    // Next-state / datapath steering
    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        w_acc       = bus.in_valid & r_in_ready;
        w_pop       = r_out_valid & bus.out_ready;

        if (bus.flush) begin
            // Offer and held entries are all dropped; skid contents are left
            // as they are because nothing reads them from EMPTY.
            w_state_nxt = ST_EMPTY;
        end else begin
            unique case (r_state)
                ST_EMPTY: begin
                    if (w_acc) begin
                        w_state_nxt = ST_FULL;
                        w_main_nxt  = bus.in_data;
                    end
                end
                ST_FULL: begin
                    if (w_acc && w_pop) begin
                        w_main_nxt = bus.in_data;
                    end else if (w_acc) begin
                        // Downstream stalled: park the new entry behind main.
                        w_state_nxt = ST_SKID;
                        w_skid_nxt  = bus.in_data;
                    end else if (w_pop) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    // in_ready is low here, so only a pop can move the state.
                    if (w_pop) begin
                        w_state_nxt = ST_FULL;
                        w_main_nxt  = r_skid;
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                end
            endcase
        end

        // Keeps out_data == BUBBLE whenever out_valid is low.
        if (w_state_nxt == ST_EMPTY) begin
            w_main_nxt = BUBBLE;
        end
    end

    // State and storage registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_main      <= BUBBLE;
            r_skid      <= BUBBLE;
        end else begin
            r_state     <= w_state_nxt;
            // Handshake outputs are registered copies of the next-state decode.
            r_in_ready  <= (w_state_nxt != ST_SKID);
            r_out_valid <= (w_state_nxt != ST_EMPTY);
            r_main      <= w_main_nxt;
            r_skid      <= w_skid_nxt;
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_main;
    assign bus.occ       = r_state;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_skid_reg
// Drives three instances (DATA_W = 64, 32, 110 with an all-ones bubble) with
// identical handshake stimulus; payloads are slices of one 128-bit value.
// A queue-based reference model (at most two entries, FIFO) predicts
// in_ready, out_valid, occ and out_data for every instance.
// ---------------------------------------------------------------------------
module tb_pipe_skid_reg;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic         out_ready;
    logic [127:0] din;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [127:0] BUB64  = 128'd0;
    localparam logic [127:0] BUB32  = 128'd0;
    localparam logic [127:0] BUB110 = {18'd0, {110{1'b1}}};

    always #5 clk = ~clk;

    pipe_skid_reg_if #(.DATA_W(64))  if64  ();
    pipe_skid_reg_if #(.DATA_W(32))  if32  ();
    pipe_skid_reg_if #(.DATA_W(110)) if110 ();

    assign if64.flush      = flush;
    assign if64.in_valid   = in_valid;
    assign if64.out_ready  = out_ready;
    assign if64.in_data    = din[63:0];
    assign if32.flush      = flush;
    assign if32.in_valid   = in_valid;
    assign if32.out_ready  = out_ready;
    assign if32.in_data    = din[31:0];
    assign if110.flush     = flush;
    assign if110.in_valid  = in_valid;
    assign if110.out_ready = out_ready;
    assign if110.in_data   = din[109:0];

    pipe_skid_reg #(.DATA_W(64)) u_dut64 (
        .clk (clk),
        .rst (rst),
        .bus (if64.slave)
    );

    pipe_skid_reg #(.DATA_W(32)) u_dut32 (
        .clk (clk),
        .rst (rst),
        .bus (if32.slave)
    );

    pipe_skid_reg #(.DATA_W(110), .BUBBLE({110{1'b1}})) u_dut110 (
        .clk (clk),
        .rst (rst),
        .bus (if110.slave)
    );

    // Reference model: the entries held by the stage, oldest first.
    logic [127:0] mq[$];
    bit           primed = 1'b0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] exp_data(input int w, input logic [127:0] bub);
        logic [127:0] mask;
        mask = (128'd1 << w) - 128'd1;
        if (mq.size() > 0) return mq[0] & mask;
        return bub;
    endfunction

    task automatic compare_all(input string tag);
        logic [127:0] e_rdy;
        logic [127:0] e_vld;
        logic [127:0] e_occ;
        e_rdy = (mq.size() < 2) ? 128'd1 : 128'd0;
        e_vld = (mq.size() > 0) ? 128'd1 : 128'd0;
        e_occ = 128'(mq.size());
        chk({tag, "_rdy64"},   128'(if64.in_ready),   e_rdy);
        chk({tag, "_vld64"},   128'(if64.out_valid),  e_vld);
        chk({tag, "_occ64"},   128'(if64.occ),        e_occ);
        chk({tag, "_dat64"},   128'(if64.out_data),   exp_data(64, BUB64));
        chk({tag, "_rdy32"},   128'(if32.in_ready),   e_rdy);
        chk({tag, "_vld32"},   128'(if32.out_valid),  e_vld);
        chk({tag, "_occ32"},   128'(if32.occ),        e_occ);
        chk({tag, "_dat32"},   128'(if32.out_data),   exp_data(32, BUB32));
        chk({tag, "_rdy110"},  128'(if110.in_ready),  e_rdy);
        chk({tag, "_vld110"},  128'(if110.out_valid), e_vld);
        chk({tag, "_occ110"},  128'(if110.occ),       e_occ);
        chk({tag, "_dat110"},  128'(if110.out_data),  exp_data(110, BUB110));
    endtask

    // One clock cycle: apply inputs, confirm outputs did not react to them
    // combinationally, advance the model on the edge, then compare.
    task automatic step(input string tag, input bit r, input bit f, input bit iv,
                        input logic [127:0] d, input bit ordy);
        int  n;
        bit  pop;
        bit  acc;
        rst       = r;
        flush     = f;
        in_valid  = iv;
        din       = d;
        out_ready = ordy;
        #1;
        if (primed) compare_all({tag, "_pre"});
        @(posedge clk);
        n   = mq.size();
        pop = (n > 0) && ordy;
        acc = iv && (n < 2);
        if (r || f) begin
            mq.delete();
        end else begin
            if (pop) void'(mq.pop_front());
            if (acc) mq.push_back(d);
        end
        #1;
        compare_all({tag, "_post"});
        primed = 1'b1;
    endtask

    localparam logic [127:0] A = 128'h0000_0000_0000_0000_AAAA_0001_1111_1111;
    localparam logic [127:0] B = 128'h0000_0000_0000_0000_BBBB_0002_2222_2222;
    localparam logic [127:0] C = 128'h0000_0000_0000_0000_CCCC_0003_3333_3333;
    localparam logic [127:0] D = 128'h0000_0000_0000_0000_DDDD_0004_4444_4444;

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; din = '0;
        @(posedge clk);
        #1;

        // Reset with an offer present
        step("rst0", 1, 0, 1, 128'hDEAD, 0);
        step("rst1", 1, 0, 1, 128'hDEAD, 0);
        chk("rst_occ",   128'(if64.occ),       128'd0);
        chk("rst_vld",   128'(if64.out_valid), 128'd0);
        chk("rst_rdy",   128'(if64.in_ready),  128'd1);
        chk("rst_dat",   128'(if64.out_data),  128'd0);
        chk("rst_dat110", 128'(if110.out_data), BUB110);

        // Streaming at full rate
        step("str0", 0, 0, 1, {64'd0, 32'h0000_0000, 32'h3401_1100}, 1);
        chk("str0_dat", 128'(if64.out_data), 128'h0000_0000_3401_1100);
        step("str1", 0, 0, 1, {64'd0, 32'h0000_0004, 32'h3402_0020}, 1);
        chk("str1_dat", 128'(if64.out_data), 128'h0000_0004_3402_0020);
        chk("str1_rdy", 128'(if64.in_ready), 128'd1);
        step("str2", 0, 0, 1, {64'd0, 32'h0000_0008, 32'h0022_1820}, 1);
        chk("str2_dat", 128'(if64.out_data), 128'h0000_0008_0022_1820);
        chk("str2_vld", 128'(if64.out_valid), 128'd1);
        step("str3", 0, 0, 0, 128'd0, 1);
        chk("str3_vld", 128'(if64.out_valid), 128'd0);

        // Back-pressure into the skid entry, then drain in order
        step("bp0", 0, 0, 1, A, 1);
        step("bp1", 0, 0, 1, B, 0);
        chk("bp1_occ", 128'(if64.occ),      128'd2);
        chk("bp1_rdy", 128'(if64.in_ready), 128'd0);
        chk("bp1_dat", 128'(if64.out_data), A & 128'hFFFF_FFFF_FFFF_FFFF);
        step("bp2", 0, 0, 1, C, 0);
        step("bp3", 0, 0, 1, C, 1);
        chk("bp3_dat", 128'(if64.out_data), B & 128'hFFFF_FFFF_FFFF_FFFF);
        step("bp4", 0, 0, 0, 128'd0, 1);
        chk("bp4_vld", 128'(if64.out_valid), 128'd0);

        // Flush while holding two entries with a third offered
        step("fl0", 0, 0, 1, A, 1);
        step("fl1", 0, 0, 1, B, 0);
        step("fl2", 0, 1, 1, C, 0);
        chk("fl2_occ", 128'(if64.occ),       128'd0);
        chk("fl2_dat", 128'(if64.out_data),  128'd0);
        chk("fl2_110", 128'(if110.out_data), BUB110);
        step("fl3", 0, 0, 0, 128'd0, 1);

        // Reset while holding two entries, then fresh traffic
        step("mr0", 0, 0, 1, A, 0);
        step("mr1", 0, 0, 1, B, 0);
        step("mr2", 1, 0, 1, C, 1);
        chk("mr2_occ", 128'(if64.occ), 128'd0);
        step("mr3", 0, 0, 1, D, 1);
        chk("mr3_dat", 128'(if64.out_data), D & 128'hFFFF_FFFF_FFFF_FFFF);
        step("mr4", 0, 0, 0, 128'd0, 1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step("rnd",
                 ($urandom_range(0, 63) == 0),
                 ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 3) != 0),
                 {$urandom, $urandom, $urandom, $urandom},
                 ($urandom_range(0, 2) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
